// File: rtl/divider.sv
// Sequential signed 8-bit restoring divider with button edge detection and
// hex display drivers. Quotient lands in B and remainder in A; X flags errors.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | waiting for a load or run event; A/B/X hold last result
//  SETUP | form |N| and |D|, clear partial remainder, arm counter
//  ITER  | one restoring shift/subtract step per cycle, 8 cycles
//  FIXUP | apply signs or error encoding and write A, B, X
module divider (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Run,
   input  logic       ClearA_LoadB,
   input  logic [7:0] S,
   output logic [7:0] Aval,
   output logic [7:0] Bval,
   output logic       X,
   output logic       Busy,
   output logic [6:0] AhexU,
   output logic [6:0] AhexL,
   output logic [6:0] BhexU,
   output logic [6:0] BhexL
);

   typedef enum logic [1:0] {IDLE, SETUP, ITER, FIXUP} state_t;

   state_t     state, state_nx;
   logic       run_prev, load_prev, run_evt, load_evt;
   logic [7:0] a_reg, b_reg, n_reg, d_reg, d_mag, q_reg;
   logic [8:0] r_reg;
   logic [2:0] cnt;
   logic       x_reg, busy_reg;

   logic [8:0] r_sh, r_sub;
   logic [7:0] q_sh, q_signed, r_signed;
   logic       r_ge;

   function automatic logic [7:0] mag(input logic [7:0] v);
      mag = v[7] ? (~v + 8'd1) : v;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] h);
      case (h)
         4'h0: seg7 = 7'h40;
         4'h1: seg7 = 7'h79;
         4'h2: seg7 = 7'h24;
         4'h3: seg7 = 7'h30;
         4'h4: seg7 = 7'h19;
         4'h5: seg7 = 7'h12;
         4'h6: seg7 = 7'h02;
         4'h7: seg7 = 7'h78;
         4'h8: seg7 = 7'h00;
         4'h9: seg7 = 7'h10;
         4'hA: seg7 = 7'h08;
         4'hB: seg7 = 7'h03;
         4'hC: seg7 = 7'h46;
         4'hD: seg7 = 7'h21;
         4'hE: seg7 = 7'h06;
         default: seg7 = 7'h0E;
      endcase
   endfunction

   // Events are registered pulses so the FSM acts one edge after detection.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         run_prev  <= 1'b0;
         load_prev <= 1'b0;
         run_evt   <= 1'b0;
         load_evt  <= 1'b0;
      end else begin
         run_prev  <= Run;
         load_prev <= ClearA_LoadB;
         run_evt   <= Run & ~run_prev;
         load_evt  <= ClearA_LoadB & ~load_prev;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (!load_evt && run_evt) state_nx = SETUP;
         SETUP:   state_nx = (d_reg == 8'h00) ? FIXUP : ITER;
         ITER:    if (cnt == 3'd0) state_nx = FIXUP;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      r_sh     = {r_reg[7:0], q_reg[7]};
      q_sh     = {q_reg[6:0], 1'b0};
      r_ge     = (r_sh >= {1'b0, d_mag});
      r_sub    = r_sh - {1'b0, d_mag};
      q_signed = (n_reg[7] ^ d_reg[7]) ? (~q_reg + 8'd1) : q_reg;
      r_signed = n_reg[7] ? (~r_reg[7:0] + 8'd1) : r_reg[7:0];
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         a_reg    <= 8'h00;
         b_reg    <= 8'h00;
         x_reg    <= 1'b0;
         busy_reg <= 1'b0;
         n_reg    <= 8'h00;
         d_reg    <= 8'h00;
         d_mag    <= 8'h00;
         q_reg    <= 8'h00;
         r_reg    <= 9'h000;
         cnt      <= 3'd0;
      end else begin
         busy_reg <= (state_nx != IDLE);
         case (state)
            IDLE: begin
               if (load_evt) begin
                  a_reg <= 8'h00;
                  b_reg <= S;
                  x_reg <= 1'b0;
               end else if (run_evt) begin
                  d_reg <= S;
                  n_reg <= b_reg;
               end
            end
            SETUP: begin
               q_reg <= mag(n_reg);
               d_mag <= mag(d_reg);
               r_reg <= 9'h000;
               cnt   <= 3'd7;
            end
            ITER: begin
               cnt   <= cnt - 3'd1;
               r_reg <= r_ge ? r_sub : r_sh;
               q_reg <= {q_sh[7:1], r_ge};
            end
            default: begin
               if (d_reg == 8'h00) begin
                  b_reg <= 8'hFF;
                  a_reg <= n_reg;
                  x_reg <= 1'b1;
               end else if (n_reg == 8'h80 && d_reg == 8'hFF) begin
                  // -128 / -1 has no 8-bit quotient
                  b_reg <= 8'h80;
                  a_reg <= 8'h00;
                  x_reg <= 1'b1;
               end else begin
                  b_reg <= q_signed;
                  a_reg <= r_signed;
                  x_reg <= 1'b0;
               end
            end
         endcase
      end
   end

   assign Aval  = a_reg;
   assign Bval  = b_reg;
   assign X     = x_reg;
   assign Busy  = busy_reg;
   assign AhexU = seg7(a_reg[7:4]);
   assign AhexL = seg7(a_reg[3:0]);
   assign BhexU = seg7(b_reg[7:4]);
   assign BhexL = seg7(b_reg[3:0]);

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for the signed restoring divider: directed cases,
// control corner cases and randomized operands against an arithmetic model.
module tb_divider;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       Run = 1'b0;
   logic       ClearA_LoadB = 1'b0;
   logic [7:0] S = 8'h00;
   logic [7:0] Aval, Bval;
   logic       X, Busy;
   logic [6:0] AhexU, AhexL, BhexU, BhexL;

   int total = 0;
   int bad = 0;

   logic [7:0] cur_a, cur_b;
   logic       cur_x;
   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   divider dut (
      .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .S(S),
      .Aval(Aval), .Bval(Bval), .X(X), .Busy(Busy),
      .AhexU(AhexU), .AhexL(AhexL), .BhexU(BhexU), .BhexL(BhexL)
   );

   always #5 Clk = ~Clk;

   // Truncating signed division with the board's error encodings.
   task automatic model_div(input logic [7:0] n, input logic [7:0] d);
      int ni, di, qi, ri;
      ni = int'($signed(n));
      di = int'($signed(d));
      if (di == 0) begin
         cur_b = 8'hFF; cur_a = n; cur_x = 1'b1;
      end else if (ni == -128 && di == -1) begin
         cur_b = 8'h80; cur_a = 8'h00; cur_x = 1'b1;
      end else begin
         qi = ni / di;
         ri = ni % di;
         cur_b = 8'(qi); cur_a = 8'(ri); cur_x = 1'b0;
      end
   endtask

   task automatic press_load(input logic [7:0] s);
      @(negedge Clk); S = s; ClearA_LoadB = 1'b1;
      @(negedge Clk); ClearA_LoadB = 1'b0;
      @(negedge Clk);
      cur_b = s; cur_a = 8'h00; cur_x = 1'b0;
   endtask

   // j counts edges after the edge that samples the Run rise.
   task automatic run_op(input logic [7:0] s, input int hold,
                         output int rise, output int fall, output int rises, output int held_bad);
      logic prev_busy;
      logic [7:0] pa, pb;
      pa = Aval; pb = Bval;
      rise = -1; fall = -1; rises = 0; held_bad = 0; prev_busy = 1'b0;
      @(negedge Clk); S = s; Run = 1'b1;
      for (int j = 0; j < hold + 20; j++) begin
         @(negedge Clk);
         if (j >= hold - 1) Run = 1'b0;
         if (Busy && !prev_busy) begin
            rises++;
            if (rise < 0) rise = j;
         end
         if (!Busy && prev_busy && fall < 0) fall = j;
         if (Busy && (Aval !== pa || Bval !== pb)) held_bad++;
         prev_busy = Busy;
      end
   endtask

   task automatic check_result(input string name);
      total++;
      if (Bval !== cur_b || Aval !== cur_a || X !== cur_x) begin
         bad++;
         $display("FAIL %s: got B=%h A=%h X=%b, want B=%h A=%h X=%b",
                  name, Bval, Aval, X, cur_b, cur_a, cur_x);
      end
   endtask

   task automatic test_reset;
      Reset = 1'b1;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      total++;
      if (Aval !== 8'h00 || Bval !== 8'h00 || X !== 1'b0 || Busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_regs: got A=%h B=%h X=%b Busy=%b, want 00 00 0 0", Aval, Bval, X, Busy);
      end
      total++;
      if (AhexU !== 7'h40 || AhexL !== 7'h40 || BhexU !== 7'h40 || BhexL !== 7'h40) begin
         bad++;
         $display("FAIL reset_hex: got %h %h %h %h, want 40 each", AhexU, AhexL, BhexU, BhexL);
      end
      Reset = 1'b0;
      cur_a = 8'h00; cur_b = 8'h00; cur_x = 1'b0;
   endtask

   task automatic do_div(input string name, input logic [7:0] d, input int exp_fall);
      int rise, fall, rises, held_bad;
      logic [7:0] n;
      n = cur_b;
      run_op(d, 1, rise, fall, rises, held_bad);
      model_div(n, d);
      check_result(name);
      total++;
      if (rise != 1 || fall != exp_fall || rises != 1) begin
         bad++;
         $display("FAIL %s_timing: busy rise=%0d fall=%0d rises=%0d, want 1 %0d 1",
                  name, rise, fall, rises, exp_fall);
      end
      total++;
      if (held_bad != 0) begin
         bad++;
         $display("FAIL %s_hold_ab: A/B changed during busy in %0d cycles, want 0", name, held_bad);
      end
   endtask

   task automatic test_basic;
      press_load(8'h64);
      total++;
      if (Bval !== 8'h64 || Aval !== 8'h00) begin
         bad++;
         $display("FAIL load: got B=%h A=%h, want 64 00", Bval, Aval);
      end
      do_div("div_100_7", 8'h07, 11);
      total++;
      if (BhexU !== seg_tab[Bval[7:4]] || BhexL !== seg_tab[Bval[3:0]] ||
          AhexU !== seg_tab[Aval[7:4]] || AhexL !== seg_tab[Aval[3:0]]) begin
         bad++;
         $display("FAIL hex: got %h %h %h %h for B=%h A=%h", BhexU, BhexL, AhexU, AhexL, Bval, Aval);
      end
      do_div("chain_14_2", 8'h02, 11);
   endtask

   task automatic test_signed;
      press_load(8'hC5);
      do_div("neg_dividend", 8'h07, 11);
      press_load(8'h07);
      do_div("neg_divisor", 8'hC5, 11);
   endtask

   task automatic test_errors;
      press_load(8'h2A);
      do_div("div_zero", 8'h00, 3);
      press_load(8'h80);
      do_div("overflow", 8'hFF, 11);
      press_load(8'h11);
      check_result("load_clears_x");
   endtask

   task automatic test_hold_run;
      int rise, fall, rises, held_bad;
      press_load(8'h64);
      run_op(8'h07, 40, rise, fall, rises, held_bad);
      model_div(8'h64, 8'h07);
      check_result("hold_run_result");
      total++;
      if (rises != 1) begin
         bad++;
         $display("FAIL hold_run_once: got %0d busy pulses, want 1", rises);
      end
   endtask

   task automatic test_simultaneous;
      int busy_seen;
      busy_seen = 0;
      @(negedge Clk); S = 8'h33; ClearA_LoadB = 1'b1; Run = 1'b1;
      for (int j = 0; j < 15; j++) begin
         @(negedge Clk);
         ClearA_LoadB = 1'b0; Run = 1'b0;
         if (Busy) busy_seen++;
      end
      cur_b = 8'h33; cur_a = 8'h00; cur_x = 1'b0;
      check_result("simul_load");
      total++;
      if (busy_seen != 0) begin
         bad++;
         $display("FAIL simul_busy: busy high %0d cycles, want 0", busy_seen);
      end
   endtask

   task automatic test_reset_mid;
      int late;
      late = 0;
      press_load(8'h64);
      @(negedge Clk); S = 8'h07; Run = 1'b1;
      @(negedge Clk); Run = 1'b0;            // after edge k
      repeat (6) @(negedge Clk);             // after edge k+6: 5th ITER cycle
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      total++;
      if (Aval !== 8'h00 || Bval !== 8'h00 || X !== 1'b0 || Busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid: got A=%h B=%h X=%b Busy=%b, want 00 00 0 0", Aval, Bval, X, Busy);
      end
      for (int j = 0; j < 15; j++) begin
         @(negedge Clk);
         if (Busy || Aval !== 8'h00 || Bval !== 8'h00) late++;
      end
      total++;
      if (late != 0) begin
         bad++;
         $display("FAIL reset_mid_late: %0d cycles with activity, want 0", late);
      end
      cur_a = 8'h00; cur_b = 8'h00; cur_x = 1'b0;
   endtask

   task automatic test_random;
      logic [7:0] n, d;
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 2) != 0) begin
            n = 8'($urandom);
            if ($urandom_range(0, 9) == 0) n = 8'h80;
            press_load(n);
         end
         d = 8'($urandom);
         if ($urandom_range(0, 7) == 0) d = 8'h00;
         if (cur_b == 8'h80 && $urandom_range(0, 1) == 0) d = 8'hFF;
         do_div($sformatf("rand%0d_%h_%h", i, cur_b, d), d, (d == 8'h00) ? 3 : 11);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_signed;
      test_errors;
      test_hold_run;
      test_simultaneous;
      test_reset_mid;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
